// File: rtl/dff_pkg.sv
// Shared constants, data word type and helpers for the dff register bank.
package dff_pkg;

    localparam int DFF_DEFAULT_WIDTH = 1;
    localparam int DFF_MAX_WIDTH     = 64;

    // Widest legal data word; narrower instances zero-extend into it.
    typedef logic [DFF_MAX_WIDTH-1:0] dff_word_t;

    function automatic logic dff_differs(input dff_word_t a, input dff_word_t b);
        return (a != b);
    endfunction

endpackage

// File: rtl/dff_if.sv
// Bundle of every dff signal; the design sees modport dut, the bench modport tb.
interface dff_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_DEFAULT_WIDTH
) ();

    typedef logic [WIDTH-1:0] data_t;

    logic  clk;
    logic  rst;
    data_t din;
    data_t dout;
    logic  chg;

    modport dut (
        input  clk,
        input  rst,
        input  din,
        output dout,
        output chg
    );

    modport tb (
        input  clk,
        output rst,
        output din,
        input  dout,
        input  chg
    );

endinterface

// File: rtl/dff_bit.sv
// Single-bit flop with asynchronous active-low reset to a configurable value.
module dff_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    // Capture on every rising edge; reset wins asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff.sv
// WIDTH-bit register built from dff_bit cells, with an optional change flag.
// Build macro DFF_CHANGE_FLAG_EN enables the registered chg output; otherwise chg is 0.
module dff
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    dff_if.dut bus
);

    logic [WIDTH-1:0] w_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        dff_bit #(
            .RESET_VAL (RESET_VAL[g])
        ) u_bit (
            .i_clk   (bus.clk),
            .i_rst_n (bus.rst),
            .i_d     (bus.din[g]),
            .o_q     (w_q[g])
        );
    end

    assign bus.dout = w_q;

`ifdef DFF_CHANGE_FLAG_EN
    logic r_chg;

    // Flags the cycle after an edge that loaded a word different from the old one.
    always_ff @(posedge bus.clk or negedge bus.rst) begin
        if (!bus.rst) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= dff_differs(dff_word_t'(bus.din), dff_word_t'(w_q));
        end
    end

    assign bus.chg = r_chg;
`else
    assign bus.chg = 1'b0;
`endif

endmodule

// File: tb/tb_dff.sv
// Scoreboard bench for dff: a 1-bit and an 8-bit (RESET_VAL 8'hA5) instance share one clock.
module tb_dff;

    localparam int             W8  = 8;
    localparam logic [W8-1:0]  RV8 = 8'hA5;
`ifdef DFF_CHANGE_FLAG_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    dff_if #(.WIDTH(1))  bus1 ();
    dff_if #(.WIDTH(W8)) bus8 ();

    assign bus1.clk = clk;
    assign bus8.clk = clk;

    dff #(.WIDTH(1),  .RESET_VAL(1'b0)) u_dut1 (.bus(bus1));
    dff #(.WIDTH(W8), .RESET_VAL(RV8))  u_dut8 (.bus(bus8));

    int checks = 0;
    int errors = 0;

    // Expected {dout, chg} per capture edge.
    logic [1:0]    q1[$];
    logic [W8:0]   q8[$];

    // Reference model: what the register last loaded.
    logic          m1_out;
    logic [W8-1:0] m8_out;

    logic [1:0]    e1;
    logic [W8:0]   e8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Set din (after a brief opposite-value glitch) and queue what the next edge must produce.
    task automatic drive_now(input logic v1, input logic [W8-1:0] v8);
        bus1.din = ~v1;
        bus8.din = ~v8;
        #2;
        check("hold1", 64'(bus1.dout), 64'(m1_out));
        check("hold8", 64'(bus8.dout), 64'(m8_out));
        bus1.din = v1;
        bus8.din = v8;
        q1.push_back({v1, CHG_EN && (v1 != m1_out)});
        q8.push_back({v8, CHG_EN && (v8 != m8_out)});
        m1_out = v1;
        m8_out = v8;
    endtask

    task automatic step(input logic v1, input logic [W8-1:0] v8);
        @(negedge clk);
        drive_now(v1, v8);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout1"}, 64'(bus1.dout), 64'(1'b0));
        check({tag, "_chg1"},  64'(bus1.chg),  64'(1'b0));
        check({tag, "_dout8"}, 64'(bus8.dout), 64'(RV8));
        check({tag, "_chg8"},  64'(bus8.chg),  64'(1'b0));
    endtask

    // Monitor: compare whatever the DUTs present just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("dout1", 64'(bus1.dout), 64'(e1[1]));
            check("chg1",  64'(bus1.chg),  64'(e1[0]));
        end
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            check("dout8", 64'(bus8.dout), 64'(e8[W8:1]));
            check("chg8",  64'(bus8.chg),  64'(e8[0]));
        end
    end

    initial begin
        bus1.rst = 1'b0;
        bus8.rst = 1'b0;
        bus1.din = 1'b1;
        bus8.din = 8'h3C;
        m1_out   = 1'b0;
        m8_out   = RV8;

        // Held in reset for two cycles with din non-zero.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_state("rst");
        end

        // Release and capture in the same cycle.
        @(negedge clk);
        bus1.rst = 1'b1;
        bus8.rst = 1'b1;
        drive_now(1'b1, 8'h3C);

        // Async reset 5 ns after an edge, then the pending capture must be lost.
        @(posedge clk);
        #5;
        bus1.rst = 1'b0;
        bus8.rst = 1'b0;
        #1;
        check_reset_state("arst");
        bus1.din = 1'b1;
        bus8.din = 8'hFF;
        @(negedge clk);
        check_reset_state("arst_hold");
        m1_out = 1'b0;
        m8_out = RV8;

        // Change-flag sequence starting from reset contents.
        @(negedge clk);
        bus1.rst = 1'b1;
        bus8.rst = 1'b1;
        drive_now(1'b0, RV8);
        step(1'b1, 8'h5A);
        step(1'b1, 8'h5A);
        step(1'b0, 8'h00);

        // Random stream.
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom()));
        end

        @(negedge clk);
        @(negedge clk);
        check("drain1", 64'(q1.size()), 64'(0));
        check("drain8", 64'(q8.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits, legal range 1..64.
REQ-002 Parameter RESET_VAL, default '0: value loaded into dout on reset, WIDTH bits wide.
REQ-003 The module SHALL have exactly one port: interface dff_if, through modport dut; all signals below belong to dff_if.
REQ-004 clk  input  1  sole clock; rising edge active.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 din  input  WIDTH  data sampled each rising clk edge.
REQ-007 dout  output  WIDTH  registered copy of din.
REQ-008 chg  output  1  change flag; see Configuration.
REQ-009 dff_if SHALL also provide modport tb, which drives rst and din and samples dout and chg.
REQ-010 dff_if SHALL expose clk as a plain variable so the bench can drive it.

Function
REQ-011 On every rising clk edge with rst high, dout SHALL take the value din had immediately before that edge; latency is exactly 1 cycle.
REQ-012 dout SHALL hold its value between rising edges; din glitches between edges SHALL have no effect.
REQ-013 No enable exists: every rising edge with rst high SHALL capture din.
REQ-014 Capturing a value equal to the current dout SHALL leave dout unchanged.
REQ-015 When din is X or Z at the sampling edge, dout SHALL propagate the same value; no masking.
REQ-016 All WIDTH bits SHALL behave identically and independently.
REQ-017 No combinational path from din to dout SHALL exist.

Reset
REQ-018 On a falling edge of rst, dout SHALL become RESET_VAL and chg SHALL become 0 immediately, without waiting for clk.
REQ-019 While rst is low, dout and chg SHALL hold their reset values regardless of clk and din.
REQ-020 On the first rising clk edge after rst goes high, the flop SHALL capture din normally.
REQ-021 When rst asserts during a cycle, the pending capture SHALL be lost.
REQ-022 When rst deasserts on the same edge as a rising clk edge, the flop SHALL treat that edge as being in reset.

Configuration
REQ-023 Macro DFF_CHANGE_FLAG_EN SHALL control the change flag.
REQ-024 With DFF_CHANGE_FLAG_EN defined, chg SHALL be registered and SHALL be 1 for exactly the cycle following any edge where the captured din differs from the previous dout; otherwise chg SHALL be 0.
REQ-025 Without DFF_CHANGE_FLAG_EN, chg SHALL be tied to constant 0.
REQ-026 The port list SHALL be identical with or without DFF_CHANGE_FLAG_EN.

Structure
REQ-027 Package dff_pkg SHALL hold DFF_DEFAULT_WIDTH (1) and a parameterized data type for din and dout.
REQ-028 Module dff and interface dff_if SHALL import dff_pkg.
REQ-029 One sub-module, dff_bit, SHALL be a single-bit async-reset flop with a reset-value parameter.
REQ-030 dff SHALL instantiate dff_bit WIDTH times via a generate loop.
REQ-031 The change-flag logic SHALL reside in dff, not in dff_bit.
REQ-032 Each dff_bit instance SHALL be reachable by a hierarchical generate-block name.

Verification
REQ-033 Scenario, reset: clk period 20 ns; assert rst=0 for 2 cycles with din=1 -> dout=0 and chg=0 throughout.
REQ-034 Scenario, capture: release rst, drive din=1 before an edge -> dout=1 after that edge and not before.
REQ-035 Scenario, random stream: 20 random din values, one per cycle -> each dout equals the din of the previous cycle; 0 mismatches.
REQ-036 Scenario, async reset: with dout=1, pull rst low mid-cycle (5 ns after an edge) -> dout=0 within the same cycle, before the next edge.
REQ-037 Scenario, change flag (DFF_CHANGE_FLAG_EN defined): din sequence 0,1,1,0 -> chg sequence 0,1,0,1 one cycle later; without the macro, chg=0 throughout.
REQ-038 Scenario, wide data: WIDTH=8, RESET_VAL=8'hA5; reset, then din=8'h3C -> dout=8'hA5 in reset and 8'h3C one cycle after release.
